// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue
//
// Purpose:
//   Writeback stage that feeds the register file write port. ALU results and
//   load results are collected into a small in-order FIFO. One entry retires
//   per cycle into the registered write port (isWrite/A3/writeData). An
//   optional bypass lookup lets decode see values that are still pending.
//
// Configuration macro:
//   WB_BYPASS_EN - when defined, the fwd1/fwd2 lookup is built. When
//                  undefined, the fwd outputs are tied to zero and no lookup
//                  logic exists. The port list is the same in both builds.
//
// Ports:
//   clock, reset             single clock, synchronous active-high reset
//   aluValid/aluAddr/aluData ALU producer (older of the two when both valid)
//   memValid/memAddr/memData load producer
//   stall                    combinational, high while count > DEPTH-2
//   overflow                 sticky, a push was attempted while stall was high
//   isWrite/A3/writeData     registered register file write port
//   A1/A2                    decode read addresses for the bypass lookup
//   fwd1Hit/fwd1Data         newest pending value for A1
//   fwd2Hit/fwd2Data         newest pending value for A2
//   count                    current FIFO occupancy
// ---------------------------------------------------------------------------
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          aluValid,
    input  logic [3:0]    aluAddr,
    input  logic [31:0]   aluData,
    input  logic          memValid,
    input  logic [3:0]    memAddr,
    input  logic [31:0]   memData,
    output logic          stall,
    output logic          overflow,
    output logic          isWrite,
    output logic [3:0]    A3,
    output logic [31:0]   writeData,
    input  logic [3:0]    A1,
    input  logic [3:0]    A2,
    output logic          fwd1Hit,
    output logic [31:0]   fwd1Data,
    output logic          fwd2Hit,
    output logic [31:0]   fwd2Data,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // FIFO storage and control state
    logic [3:0]    addr_q  [DEPTH];
    logic [3:0]    addr_d  [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [31:0]   data_d  [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    // Registered write port
    logic          is_write_q, is_write_d;
    logic [3:0]    a3_q, a3_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          stall_s;
    logic          pop_s;
    logic          push_alu_s;
    logic          push_mem_s;
    logic [PW-1:0] mem_slot_s;
    logic [CW-1:0] push_cnt_s;
    logic [CW-1:0] pop_cnt_s;

    // Stall, push and pop qualification. Stalling at count > DEPTH-2 keeps
    // room for two pushes, so a dual push never has to be split.
    always_comb begin
        stall_s    = (count_q > CW'(DEPTH - 2));
        pop_s      = (count_q != {CW{1'b0}});
        push_alu_s = aluValid & ~stall_s;
        push_mem_s = memValid & ~stall_s;
        push_cnt_s = {{(CW-1){1'b0}}, push_alu_s} + {{(CW-1){1'b0}}, push_mem_s};
        pop_cnt_s  = {{(CW-1){1'b0}}, pop_s};
        // The load entry lands behind the ALU entry when both push together.
        mem_slot_s = push_alu_s ? (tail_q + PW'(1'b1)) : tail_q;
    end

    // Entry writes: each slot takes the ALU result, the load result or holds.
    // Pushes never collide with the head because they only happen when at
    // least two slots are free.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_alu_s && (tail_q == PW'(i))) begin
                addr_d[i] = aluAddr;
                data_d[i] = aluData;
            end else if (push_mem_s && (mem_slot_s == PW'(i))) begin
                addr_d[i] = memAddr;
                data_d[i] = memData;
            end else begin
                addr_d[i] = addr_q[i];
                data_d[i] = data_q[i];
            end
        end
    end

    // Pointer, occupancy and sticky overflow next-state. Pointers wrap
    // naturally because DEPTH is a power of two.
    always_comb begin
        tail_d     = tail_q + PW'(push_cnt_s);
        head_d     = head_q + PW'(pop_cnt_s);
        count_d    = count_q + push_cnt_s - pop_cnt_s;
        overflow_d = overflow_q | (stall_s & (aluValid | memValid));
    end

    // Retire the head entry into the write port; hold address/data when idle.
    always_comb begin
        if (pop_s) begin
            is_write_d = 1'b1;
            a3_d       = addr_q[head_q];
            wdata_d    = data_q[head_q];
        end else begin
            is_write_d = 1'b0;
            a3_d       = a3_q;
            wdata_d    = wdata_q;
        end
    end

    // State registers with synchronous reset; reset discards all entries.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= 4'd0;
                data_q[i] <= 32'd0;
            end
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            overflow_q <= 1'b0;
            is_write_q <= 1'b0;
            a3_q       <= 4'd0;
            wdata_q    <= 32'd0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            is_write_q <= is_write_d;
            a3_q       <= a3_d;
            wdata_q    <= wdata_d;
        end
    end

`ifdef WB_BYPASS_EN
    // Bypass lookup. Candidates are scanned oldest to newest (output register
    // first, then head .. tail-1) so the last match seen is the newest one.
    always_comb begin
        fwd1Hit  = is_write_q & (a3_q == A1);
        fwd1Data = (is_write_q && (a3_q == A1)) ? wdata_q : 32'd0;
        fwd2Hit  = is_write_q & (a3_q == A2);
        fwd2Data = (is_write_q && (a3_q == A2)) ? wdata_q : 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd1Data = ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == A1))
                       ? data_q[head_q + PW'(i)] : fwd1Data;
            fwd1Hit  = fwd1Hit | ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == A1));
            fwd2Data = ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == A2))
                       ? data_q[head_q + PW'(i)] : fwd2Data;
            fwd2Hit  = fwd2Hit | ((CW'(i) < count_q) && (addr_q[head_q + PW'(i)] == A2));
        end
    end
`else
    // Read addresses are only consumed by the bypass lookup.
    logic bypass_unused_s;

    // Bypass disabled: forwarding outputs are constant zero.
    always_comb begin
        bypass_unused_s = ^{A1, A2};
        fwd1Hit         = 1'b0;
        fwd1Data        = 32'd0;
        fwd2Hit         = 1'b0;
        fwd2Data        = 32'd0;
    end
`endif

    // Output connections
    always_comb begin
        stall     = stall_s;
        overflow  = overflow_q;
        isWrite   = is_write_q;
        A3        = a3_q;
        writeData = wdata_q;
        count     = count_q;
    end

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          aluValid, memValid;
    logic [3:0]    aluAddr, memAddr;
    logic [31:0]   aluData, memData;
    logic          stall, overflow, isWrite;
    logic [3:0]    A3, A1, A2;
    logic [31:0]   writeData;
    logic          fwd1Hit, fwd2Hit;
    logic [31:0]   fwd1Data, fwd2Data;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;

    // Reference model: in-order queue of {addr, data} plus the write port.
    logic [35:0] mq[$];
    logic        m_wr;
    logic [3:0]  m_a3;
    logic [31:0] m_wd;
    logic        m_ovf;

    always #5 clock = ~clock;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .aluValid(aluValid), .aluAddr(aluAddr), .aluData(aluData),
        .memValid(memValid), .memAddr(memAddr), .memData(memData),
        .stall(stall), .overflow(overflow),
        .isWrite(isWrite), .A3(A3), .writeData(writeData),
        .A1(A1), .A2(A2),
        .fwd1Hit(fwd1Hit), .fwd1Data(fwd1Data),
        .fwd2Hit(fwd2Hit), .fwd2Data(fwd2Data),
        .count(count)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one cycle, advance the model across the edge, settle #1 after it.
    task automatic tick(input logic r, input logic av, input logic [3:0] aa, input logic [31:0] ad,
                        input logic mv, input logic [3:0] ma, input logic [31:0] md);
        bit full;
        logic [35:0] e;
        reset = r; aluValid = av; aluAddr = aa; aluData = ad;
        memValid = mv; memAddr = ma; memData = md;
        @(posedge clock);
        if (r) begin
            mq.delete();
            m_wr = 1'b0; m_a3 = 4'd0; m_wd = 32'd0; m_ovf = 1'b0;
        end else begin
            full = (mq.size() > DEPTH - 2);
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_wr = 1'b1; m_a3 = e[35:32]; m_wd = e[31:0];
            end else begin
                m_wr = 1'b0;
            end
            if (full) begin
                if (av || mv) m_ovf = 1'b1;
            end else begin
                if (av) mq.push_back({aa, ad});
                if (mv) mq.push_back({ma, md});
            end
        end
        #1;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    // Newest pending value for an address, searched newest to oldest.
    function automatic logic [32:0] exp_fwd(input logic [3:0] a);
        if (!BYP) return 33'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i][35:32] == a) return {1'b1, mq[i][31:0]};
        if (m_wr && (m_a3 == a)) return {1'b1, m_wd};
        return 33'd0;
    endfunction

    task automatic test_reset();
        A1 = 4'd0; A2 = 4'd0;
        tick(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (isWrite !== 1'b0) begin failures++; $display("FAIL reset_iswrite got=%b exp=0", isWrite); end
        checks++; if (A3 !== 4'd0) begin failures++; $display("FAIL reset_a3 got=%0d exp=0", A3); end
        checks++; if (writeData !== 32'd0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", writeData); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    endtask

    task automatic test_single_push();
        tick(1'b0, 1'b1, 4'd4, 32'h2A, 1'b0, 4'd0, 32'd0);
        checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d exp=1", count); end
        checks++; if (isWrite !== 1'b0) begin failures++; $display("FAIL single_iswrite1 got=%b exp=0", isWrite); end
        idle();
        checks++; if ({isWrite, A3, writeData} !== {1'b1, 4'd4, 32'h2A}) begin
            failures++; $display("FAIL single_write got=%b/%0d/%h exp=1/4/2a", isWrite, A3, writeData); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_count2 got=%0d exp=0", count); end
        idle();
        checks++; if (isWrite !== 1'b0) begin failures++; $display("FAIL single_iswrite3 got=%b exp=0", isWrite); end
    endtask

    task automatic test_dual_push();
        tick(1'b0, 1'b1, 4'd3, 32'h11, 1'b1, 4'd5, 32'h22);
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL dual_count2 got=%0d exp=2", count); end
        idle();
        checks++; if ({isWrite, A3, writeData, count} !== {1'b1, 4'd3, 32'h11, 3'd1}) begin
            failures++; $display("FAIL dual_first got=%b/%0d/%h/%0d exp=1/3/11/1", isWrite, A3, writeData, count); end
        idle();
        checks++; if ({isWrite, A3, writeData, count} !== {1'b1, 4'd5, 32'h22, 3'd0}) begin
            failures++; $display("FAIL dual_second got=%b/%0d/%h/%0d exp=1/5/22/0", isWrite, A3, writeData, count); end
        idle();
        checks++; if (isWrite !== 1'b0) begin failures++; $display("FAIL dual_idle got=%b exp=0", isWrite); end
    endtask

    task automatic test_fill_stall();
        tick(1'b0, 1'b1, 4'd1, 32'hA1, 1'b1, 4'd2, 32'hA2);
        checks++; if ({count, stall} !== {3'd2, 1'b0}) begin
            failures++; $display("FAIL fill_count2 got=%0d/%b exp=2/0", count, stall); end
        tick(1'b0, 1'b1, 4'd3, 32'hA3, 1'b1, 4'd4, 32'hA4);
        checks++; if ({count, stall} !== {3'd3, 1'b1}) begin
            failures++; $display("FAIL fill_stall got=%0d/%b exp=3/1", count, stall); end
        checks++; if ({A3, writeData} !== {4'd1, 32'hA1}) begin
            failures++; $display("FAIL fill_ret1 got=%0d/%h exp=1/a1", A3, writeData); end
        tick(1'b0, 1'b1, 4'd8, 32'h33, 1'b0, 4'd0, 32'd0);
        checks++; if ({count, overflow} !== {3'd2, 1'b1}) begin
            failures++; $display("FAIL fill_overflow got=%0d/%b exp=2/1", count, overflow); end
        checks++; if ({A3, writeData} !== {4'd2, 32'hA2}) begin
            failures++; $display("FAIL fill_ret2 got=%0d/%h exp=2/a2", A3, writeData); end
        idle();
        checks++; if ({A3, writeData, count} !== {4'd3, 32'hA3, 3'd1}) begin
            failures++; $display("FAIL fill_ret3 got=%0d/%h/%0d exp=3/a3/1", A3, writeData, count); end
        idle();
        checks++; if ({isWrite, A3, writeData, count} !== {1'b1, 4'd4, 32'hA4, 3'd0}) begin
            failures++; $display("FAIL fill_ret4 got=%b/%0d/%h/%0d exp=1/4/a4/0", isWrite, A3, writeData, count); end
        idle();
        checks++; if ({isWrite, overflow} !== {1'b0, 1'b1}) begin
            failures++; $display("FAIL fill_drained got=%b/%b exp=0/1", isWrite, overflow); end
        tick(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_bypass();
        logic [32:0] e200;
        e200 = BYP ? {1'b1, 32'h200} : 33'd0;
        A1 = 4'd7; A2 = 4'd9;
        tick(1'b0, 1'b1, 4'd7, 32'h100, 1'b1, 4'd7, 32'h200);
        for (int c = 0; c < 3; c++) begin
            checks++; if ({fwd1Hit, fwd1Data} !== e200) begin
                failures++; $display("FAIL bypass_a1_c%0d got=%b/%h exp=%b/%h", c, fwd1Hit, fwd1Data, e200[32], e200[31:0]); end
            checks++; if ({fwd2Hit, fwd2Data} !== 33'd0) begin
                failures++; $display("FAIL bypass_a2_c%0d got=%b/%h exp=0/0", c, fwd2Hit, fwd2Data); end
            if (c == 1) begin
                checks++; if ({isWrite, A3, writeData} !== {1'b1, 4'd7, 32'h100}) begin
                    failures++; $display("FAIL bypass_wr1 got=%b/%0d/%h exp=1/7/100", isWrite, A3, writeData); end
            end else if (c == 2) begin
                checks++; if ({isWrite, A3, writeData} !== {1'b1, 4'd7, 32'h200}) begin
                    failures++; $display("FAIL bypass_wr2 got=%b/%0d/%h exp=1/7/200", isWrite, A3, writeData); end
            end
            idle();
        end
        checks++; if ({fwd1Hit, fwd1Data, isWrite} !== 34'd0) begin
            failures++; $display("FAIL bypass_done got=%b/%h/%b exp=0/0/0", fwd1Hit, fwd1Data, isWrite); end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1, 4'd10, 32'h5, 1'b1, 4'd11, 32'h6);
        tick(1'b0, 1'b1, 4'd12, 32'h7, 1'b1, 4'd13, 32'h8);
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_count got=%0d exp=3", count); end
        tick(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        checks++; if ({count, isWrite} !== {3'd0, 1'b0}) begin
            failures++; $display("FAIL mid_reset got=%0d/%b exp=0/0", count, isWrite); end
        for (int c = 0; c < 3; c++) begin
            idle();
            checks++; if ({count, isWrite} !== {3'd0, 1'b0}) begin
                failures++; $display("FAIL mid_after_c%0d got=%0d/%b exp=0/0", c, count, isWrite); end
        end
    endtask

    task automatic test_random();
        logic [32:0] e1, e2;
        for (int n = 0; n < 600; n++) begin
            A1 = 4'($urandom_range(0, 5));
            A2 = 4'($urandom_range(0, 15));
            tick(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 5)), $urandom,
                 ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 5)), $urandom);
            e1 = exp_fwd(A1);
            e2 = exp_fwd(A2);
            checks++; if (count !== CW'(mq.size())) begin
                failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, mq.size()); end
            checks++; if (stall !== (mq.size() > DEPTH - 2)) begin
                failures++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, mq.size() > DEPTH - 2); end
            checks++; if ({isWrite, A3, writeData} !== {m_wr, m_a3, m_wd}) begin
                failures++; $display("FAIL rnd_write n=%0d got=%b/%0d/%h exp=%b/%0d/%h", n, isWrite, A3, writeData, m_wr, m_a3, m_wd); end
            checks++; if (overflow !== m_ovf) begin
                failures++; $display("FAIL rnd_overflow n=%0d got=%b exp=%b", n, overflow, m_ovf); end
            checks++; if ({fwd1Hit, fwd1Data} !== e1) begin
                failures++; $display("FAIL rnd_fwd1 n=%0d got=%b/%h exp=%b/%h", n, fwd1Hit, fwd1Data, e1[32], e1[31:0]); end
            checks++; if ({fwd2Hit, fwd2Data} !== e2) begin
                failures++; $display("FAIL rnd_fwd2 n=%0d got=%b/%h exp=%b/%h", n, fwd2Hit, fwd2Data, e2[32], e2[31:0]); end
        end
    endtask

    initial begin
        m_wr = 1'b0; m_a3 = 4'd0; m_wd = 32'd0; m_ovf = 1'b0;
        reset = 1'b1; aluValid = 1'b0; memValid = 1'b0;
        aluAddr = 4'd0; memAddr = 4'd0; aluData = 32'd0; memData = 32'd0;
        A1 = 4'd0; A2 = 4'd0;
        test_reset();
        test_single_push();
        test_dual_push();
        test_fill_stall();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Writeback stage directly upstream of the processor register file; it is the sole driver of the register file write port (isWrite, A3, writeData).
- Accepts results from two producers: the ALU result and the load-data result. Both may arrive in the same cycle.
- Buffers the results in a small in-order FIFO and retires one write per cycle.
- Exposes a bypass lookup so decode can read values that are not yet written into the register file.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, ≥2.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- aluValid  in  1  ALU result present this cycle.
- aluAddr  in  4  ALU destination register.
- aluData  in  32  ALU result.
- memValid  in  1  load result present this cycle.
- memAddr  in  4  load destination register.
- memData  in  32  load data.
- stall  out  1  upstream must hold off; combinational, equals count > DEPTH-2.
- overflow  out  1  sticky: a push was attempted while stall was high.
- isWrite  out  1  register file write enable (registered).
- A3  out  4  register file write address (registered).
- writeData  out  32  register file write data (registered).
- A1  in  4  decode read address 1.
- A2  in  4  decode read address 2.
- fwd1Hit  out  1  a pending write to A1 exists.
- fwd1Data  out  32  newest pending value for A1.
- fwd2Hit  out  1  a pending write to A2 exists.
- fwd2Data  out  32  newest pending value for A2.
- count  out  CW  current FIFO occupancy.

Behaviour:
- Reset: count=0; head and tail pointers 0; isWrite=0; A3=0; writeData=0; overflow=0.
  - Reset mid-operation discards every queued entry. No register file write results from discarded entries.
- Push, when stall=0:
  - Each valid producer enqueues {addr, data} at the tail on the posedge.
  - If aluValid and memValid are both high, the ALU entry is enqueued first (older), then the mem entry. Tail advances by 2.
- Push while stall=1:
  - The requests are dropped and not enqueued.
  - overflow sets on that edge and stays 1 until reset.
- Pop: every posedge with count>0 (evaluated before that edge's pushes):
  - Head entry loads into A3/writeData, isWrite<=1, head advances.
  - If count=0, isWrite<=0; A3 and writeData hold their values.
- Count: count_next = count + pushes − pop. A push and a pop in the same cycle are legal. With count≤DEPTH-2, two pushes always fit.
- Pointers: wrap modulo DEPTH.
- Latency:
  - Result presented at edge N → enqueued at N.
  - If the queue was empty, it is driven on isWrite/A3/writeData after N+1.
  - The register file commits it at edge N+2.
- Ordering: strictly in-order. Multiple writes to the same register retire oldest first, so the last write wins.
- Bypass lookup: combinational over the valid queue entries plus the output register when isWrite=1.
  - fwdXHit=1 if any of those candidates has addr==AX.
  - fwdXData comes from the newest match. Age order, newest to oldest: tail−1 … head, then the output register.
  - No match: hit=0, data=0.
  - Same-cycle producer inputs are not forwarded; the consumer handles those separately.
- All 16 addresses are treated identically; the block applies no special handling to any register.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: bypass lookup as described above.
- Undefined: fwd1Hit=fwd2Hit=0 and fwd1Data=fwd2Data=0 constantly, and the lookup logic is absent. Ports remain so the instantiation is unchanged. Decode must stall on RAW hazards.

Test Plan:
- Reset then a single push: aluValid=1, aluAddr=4, aluData=0x2A at edge 1.
  - → count=1 after edge 1.
  - → isWrite=1, A3=4, writeData=0x2A after edge 2; count=0.
  - → isWrite=0 after edge 3.
- Dual push: aluAddr=3/0x11 and memAddr=5/0x22 in the same cycle.
  - → writes retire R3=0x11, then R5=0x22 on consecutive cycles; count goes 2,1,0.
- Fill and stall (DEPTH=4):
  - Two dual pushes on back-to-back cycles → count reaches 3 (one pop occurs) and stall=1.
  - A push attempted while stall=1 → overflow=1, count unchanged by that push; entries retire in order.
- Bypass (WB_BYPASS_EN defined):
  - Queue R7=0x100 then R7=0x200, with A1=7 → fwd1Hit=1, fwd1Data=0x200 until both retire, then fwd1Hit=0.
  - A2=9 with no pending write → fwd2Hit=0, fwd2Data=0.
- Reset mid-operation: 3 entries queued, reset=1 for one cycle.
  - → count=0, isWrite=0 the next cycle, and no further writes.
- Macro undefined: repeat the bypass scenario → fwd1Hit=0 and fwd1Data=0 throughout; write sequence identical to the defined case.
